// File: rtl/unsigned_mul_8x8_ha_array_acc.sv
// unsigned_mul_8x8_ha_array_acc: weights and accumulates the four HA-array row pairs into a 16-bit product
module unsigned_mul_8x8_ha_array_acc #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        overflow
);
  localparam int N_ACC = 4 / ROWS_PER_CYCLE;
  generate
    if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2 && ROWS_PER_CYCLE != 4) begin : g_bad_rpc
      $error("ROWS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_next;
  logic [8:0]  t [4];
  logic [6:0]  b [4];
  logic [16:0] r [4];
  logic [16:0] acc, add;
  logic [1:0]  cnt;
  logic        last;
  assign last      = cnt == 2'(N_ACC - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign product   = acc[15:0];
  assign overflow  = acc[16];
  always_comb begin
    for (int k = 0; k < 4; k++)
      r[k] = ({8'd0, t[k]} + {8'd0, b[k], 2'b00}) << (2 * k);
  end
  // rows belonging to the current slot, in ascending k
  always_comb begin
    add = '0;
    for (int j = 0; j < 4; j++)
      add = add + ((j / ROWS_PER_CYCLE) == int'(cnt) ? r[j] : 17'd0);
  end
  always_comb begin
    state_next = state == IDLE ? (in_valid ? ACC : IDLE) :
                 state == ACC  ? (last ? DONE : ACC) :
                                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      for (int k = 0; k < 4; k++) begin
        t[k] <= '0;
        b[k] <= '0;
      end
    end else if (state == IDLE && in_valid) begin
      acc  <= '0;
      cnt  <= '0;
      t[0] <= ha_array_0_t;
      t[1] <= ha_array_1_t;
      t[2] <= ha_array_2_t;
      t[3] <= ha_array_3_t;
      b[0] <= ha_array_0_b;
      b[1] <= ha_array_1_b;
      b[2] <= ha_array_2_b;
      b[3] <= ha_array_3_b;
    end else if (state == ACC) begin
      acc <= acc + add;
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_acc.sv
// tb_unsigned_mul_8x8_ha_array_acc: directed and random checks of the row accumulator for RPC 1, 2 and 4
module tb_unsigned_mul_8x8_ha_array_acc;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic [8:0]  t [4];
  logic [6:0]  b [4];
  logic        iv [3];
  logic        ordy [3];
  logic        ir [3];
  logic        ov [3];
  logic        of [3];
  logic [15:0] pr [3];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      unsigned_mul_8x8_ha_array_acc #(.ROWS_PER_CYCLE(1 << g)) dut (
        .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]),
        .ha_array_0_b(b[0]), .ha_array_1_b(b[1]), .ha_array_2_b(b[2]), .ha_array_3_b(b[3]),
        .ha_array_0_t(t[0]), .ha_array_1_t(t[1]), .ha_array_2_t(t[2]), .ha_array_3_t(t[3]),
        .out_valid(ov[g]), .out_ready(ordy[g]), .product(pr[g]), .overflow(of[g])
      );
    end
  endgenerate
  function automatic logic [16:0] model();
    int s = 0;
    for (int k = 0; k < 4; k++) s += (int'(t[k]) + 4 * int'(b[k])) * (4 ** k);
    return 17'(s);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clear_rows();
    for (int k = 0; k < 4; k++) begin
      t[k] = '0;
      b[k] = '0;
    end
  endtask
  task automatic rand_rows();
    for (int k = 0; k < 4; k++) begin
      t[k] = 9'($urandom);
      b[k] = 7'($urandom);
    end
  endtask
  task automatic run(input int d, input logic [16:0] e, input int lat, input string tag);
    int n = 0;
    chk({tag, "_ready"}, 32'(ir[d]), 1);
    iv[d] = 1;
    step();
    iv[d] = 0;
    while (ov[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_product"}, 32'(pr[d]), 32'(e[15:0]));
    chk({tag, "_overflow"}, 32'(of[d]), 32'(e[16]));
    if (ordy[d]) begin
      step();
      chk({tag, "_valid_drop"}, 32'(ov[d]), 0);
      chk({tag, "_ready_back"}, 32'(ir[d]), 1);
    end
  endtask
  initial begin
    logic [16:0] q[$];
    logic [16:0] e;
    int got, last_c, n;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1;
      ordy[d] = 1;
    end
    rand_rows();
    repeat (3) begin
      step();
      rand_rows();
    end
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 32'(ir[d]), 1);
      chk("rst_out_valid", 32'(ov[d]), 0);
      chk("rst_product", 32'(pr[d]), 0);
      chk("rst_overflow", 32'(of[d]), 0);
      iv[d] = 0;
    end
    rst = 0;
    step();
    clear_rows(); t[0][0] = 1'b1; run(0, 17'd1, 4, "bit_t0_0");
    clear_rows(); t[3][8] = 1'b1; run(0, 17'd16384, 4, "bit_t3_8");
    clear_rows(); b[2][6] = 1'b1; run(0, 17'd4096, 4, "bit_b2_6");
    clear_rows(); b[1][0] = 1'b1; run(0, 17'd16, 4, "bit_b1_0");
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) begin
        t[k] = 9'h1FF;
        b[k] = 7'h7F;
      end
      run(d, 17'd86615, 4 >> d, "all_ones");
    end
    clear_rows();
    t[0] = 9'h1FF;
    ordy[0] = 0;
    run(0, 17'd511, 4, "bp");
    repeat (10) begin
      iv[0] = 1;
      rand_rows();
      step();
      chk("bp_hold_valid", 32'(ov[0]), 1);
      chk("bp_hold_product", 32'(pr[0]), 511);
      chk("bp_hold_in_ready", 32'(ir[0]), 0);
    end
    iv[0] = 0;
    ordy[0] = 1;
    step();
    chk("bp_release_valid", 32'(ov[0]), 0);
    chk("bp_release_ready", 32'(ir[0]), 1);
    got = 0;
    last_c = -1;
    n = 0;
    iv[0] = 1;
    rand_rows();
    while (got < 8 && n < 200) begin
      if (ir[0]) q.push_back(model());
      step();
      n++;
      rand_rows();
      if (ov[0]) begin
        e = q.size() > 0 ? q.pop_front() : 17'bx;
        chk("b2b_product", 32'(pr[0]), 32'(e[15:0]));
        chk("b2b_overflow", 32'(of[0]), 32'(e[16]));
        if (last_c >= 0) chk("b2b_spacing", cyc - last_c, 6);
        last_c = cyc;
        got++;
        if (got == 8) iv[0] = 0;
      end
    end
    iv[0] = 0;
    chk("b2b_count", got, 8);
    step();
    clear_rows();
    t[2][3] = 1'b1;
    iv[0] = 1;
    step();
    iv[0] = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("midrst_in_ready", 32'(ir[0]), 1);
    chk("midrst_out_valid", 32'(ov[0]), 0);
    chk("midrst_product", 32'(pr[0]), 0);
    n = 0;
    repeat (6) begin
      step();
      n += ov[0] ? 1 : 0;
    end
    chk("midrst_no_valid", n, 0);
    clear_rows();
    t[1][0] = 1'b1;
    run(0, 17'd4, 4, "after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
